data_mem_responder: RTL and testbench

DATA_MEM_RESPONDER -- requirements
Module: data_mem_responder

---
 rtl/data_mem_responder_pkg.sv | 14 +
 rtl/data_mem_array.sv | 35 +++
 rtl/data_mem_responder.sv | 162 ++++++++++++++++
 tb/tb_data_mem_responder.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/data_mem_responder_pkg.sv
// Shared definitions for the data memory responder: FSM encoding and latency limits.
package data_mem_responder_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_RESP = 2'd2
    } state_e;

    localparam int unsigned LAT_MIN = 1;
    localparam int unsigned LAT_MAX = 15;
    localparam int unsigned CNT_W   = 4;

endpackage

// File: rtl/data_mem_array.sv
// Word storage: one synchronous write port and one synchronous read port, no reset.
module data_mem_array #(
    parameter int DATA_WIDTH  = 32,
    parameter int DEPTH_WORDS = 1024
) (
    input  logic                           clk,
    input  logic                           wr_en,
    input  logic [$clog2(DEPTH_WORDS)-1:0] wr_idx,
    input  logic [DATA_WIDTH-1:0]          wr_data,
    input  logic                           rd_en,
    input  logic [$clog2(DEPTH_WORDS)-1:0] rd_idx,
    output logic [DATA_WIDTH-1:0]          rd_data
);

    logic [DATA_WIDTH-1:0] mem_array [DEPTH_WORDS];
    logic [DATA_WIDTH-1:0] rd_data_q;
    logic [DATA_WIDTH-1:0] rd_data_d;

    always_comb begin
        rd_data_d = rd_data_q;
        if (rd_en) begin
            rd_data_d = mem_array[rd_idx];
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_array[wr_idx] <= wr_data;
        end
        rd_data_q <= rd_data_d;
    end

    assign rd_data = rd_data_q;

endmodule

// File: rtl/data_mem_responder.sv
// Multi-cycle data memory responder: accepts one read/write transaction, stalls the
// CPU for ACCESS_LATENCY+1 cycles, then presents a one-cycle response.
module data_mem_responder
    import data_mem_responder_pkg::*;
#(
    parameter int DATA_WIDTH      = 32,
    parameter int DATA_ADDR_WIDTH = 32,
    parameter int DEPTH_WORDS     = 1024,
    parameter int ACCESS_LATENCY  = 2
) (
    input  logic                       cpu_clk,
    input  logic                       cpu_rst_n,
    input  logic                       mem_read,
    input  logic [DATA_ADDR_WIDTH-1:0] mem_raddr,
    input  logic                       mem_write,
    input  logic [DATA_ADDR_WIDTH-1:0] mem_waddr,
    input  logic [DATA_WIDTH-1:0]      mem_wdata,
    output logic [DATA_WIDTH-1:0]      mem_rdata,
    output logic                       mem_hazard,
    output logic                       err_oob
);

    localparam int IDX_W = $clog2(DEPTH_WORDS);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(ACCESS_LATENCY - 1);

    if (ACCESS_LATENCY < int'(LAT_MIN) || ACCESS_LATENCY > int'(LAT_MAX)) begin : g_lat_chk
        $error("ACCESS_LATENCY outside the supported range");
    end

    function automatic logic [IDX_W-1:0] word_idx(input logic [DATA_ADDR_WIDTH-1:0] addr);
        return addr[IDX_W+1:2];
    endfunction

    // Any bit set above the word-index field places the word beyond the array.
    function automatic logic is_oob(input logic [DATA_ADDR_WIDTH-1:0] addr);
        return (addr >> (IDX_W + 2)) != '0;
    endfunction

    state_e                     state_q, state_d;
    logic [CNT_W-1:0]           cnt_q, cnt_d;
    logic                       rd_req_q, rd_req_d;
    logic                       wr_req_q, wr_req_d;
    logic [DATA_ADDR_WIDTH-1:0] raddr_q, raddr_d;
    logic [DATA_ADDR_WIDTH-1:0] waddr_q, waddr_d;
    logic [DATA_WIDTH-1:0]      wdata_q, wdata_d;
    logic [DATA_WIDTH-1:0]      mem_rdata_q, mem_rdata_d;
    logic                       err_oob_q, err_oob_d;

    logic                       hazard;
    logic                       arr_wr_en;
    logic                       arr_rd_en;
    logic [DATA_WIDTH-1:0]      arr_rdata;
    logic                       raddr_oob;
    logic                       waddr_oob;
    logic                       same_word;

    assign raddr_oob = is_oob(raddr_q);
    assign waddr_oob = is_oob(waddr_q);
    assign same_word = word_idx(raddr_q) == word_idx(waddr_q);

    // The array read is launched at acceptance so its data is ready by completion;
    // a same-word write in the same transaction is forwarded instead.
    data_mem_array #(
        .DATA_WIDTH  (DATA_WIDTH),
        .DEPTH_WORDS (DEPTH_WORDS)
    ) u_array (
        .clk     (cpu_clk),
        .wr_en   (arr_wr_en),
        .wr_idx  (word_idx(waddr_q)),
        .wr_data (wdata_q),
        .rd_en   (arr_rd_en),
        .rd_idx  (word_idx(mem_raddr)),
        .rd_data (arr_rdata)
    );

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        rd_req_d    = rd_req_q;
        wr_req_d    = wr_req_q;
        raddr_d     = raddr_q;
        waddr_d     = waddr_q;
        wdata_d     = wdata_q;
        mem_rdata_d = mem_rdata_q;
        err_oob_d   = err_oob_q;
        hazard      = 1'b0;
        arr_wr_en   = 1'b0;
        arr_rd_en   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (mem_read || mem_write) begin
                    hazard    = 1'b1;
                    rd_req_d  = mem_read;
                    wr_req_d  = mem_write;
                    raddr_d   = mem_raddr;
                    waddr_d   = mem_waddr;
                    wdata_d   = mem_wdata;
                    cnt_d     = CNT_LOAD;
                    arr_rd_en = cpu_rst_n && mem_read;
                    state_d   = ST_BUSY;
                end
            end
            ST_BUSY: begin
                hazard = 1'b1;
                if (cnt_q == '0) begin
                    arr_wr_en = cpu_rst_n && wr_req_q && !waddr_oob;
                    if (rd_req_q) begin
                        if (raddr_oob) begin
                            mem_rdata_d = '0;
                        end else if (wr_req_q && !waddr_oob && same_word) begin
                            mem_rdata_d = wdata_q;
                        end else begin
                            mem_rdata_d = arr_rdata;
                        end
                    end
                    if ((rd_req_q && raddr_oob) || (wr_req_q && waddr_oob)) begin
                        err_oob_d = 1'b1;
                    end
                    state_d = ST_RESP;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            ST_RESP: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge cpu_clk) begin
        if (!cpu_rst_n) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            rd_req_q    <= 1'b0;
            wr_req_q    <= 1'b0;
            raddr_q     <= '0;
            waddr_q     <= '0;
            wdata_q     <= '0;
            mem_rdata_q <= '0;
            err_oob_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            rd_req_q    <= rd_req_d;
            wr_req_q    <= wr_req_d;
            raddr_q     <= raddr_d;
            waddr_q     <= waddr_d;
            wdata_q     <= wdata_d;
            mem_rdata_q <= mem_rdata_d;
            err_oob_q   <= err_oob_d;
        end
    end

    assign mem_rdata  = mem_rdata_q;
    assign err_oob    = err_oob_q;
    assign mem_hazard = hazard && cpu_rst_n;

endmodule

// File: tb/tb_data_mem_responder.sv
// Randomized self-checking bench for data_mem_responder against a word-level memory model.
module tb_data_mem_responder;

    localparam int DW    = 32;
    localparam int AW    = 32;
    localparam int DEPTH = 1024;
    localparam int LAT   = 2;

    logic          cpu_clk = 1'b0;
    logic          cpu_rst_n;
    logic          mem_read;
    logic [AW-1:0] mem_raddr;
    logic          mem_write;
    logic [AW-1:0] mem_waddr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;
    logic          mem_hazard;
    logic          err_oob;

    always #5 cpu_clk = ~cpu_clk;

    data_mem_responder #(
        .DATA_WIDTH      (DW),
        .DATA_ADDR_WIDTH (AW),
        .DEPTH_WORDS     (DEPTH),
        .ACCESS_LATENCY  (LAT)
    ) dut (
        .cpu_clk    (cpu_clk),
        .cpu_rst_n  (cpu_rst_n),
        .mem_read   (mem_read),
        .mem_raddr  (mem_raddr),
        .mem_write  (mem_write),
        .mem_waddr  (mem_waddr),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata),
        .mem_hazard (mem_hazard),
        .err_oob    (err_oob)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: word-indexed contents, last read result, sticky error.
    logic [DW-1:0] ref_mem [int];
    logic [DW-1:0] ref_rdata;
    bit            ref_rdata_known;
    bit            ref_err;

    task automatic check_eq(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    function automatic bit addr_oob(input logic [AW-1:0] a);
        return (a / 4) >= DEPTH;
    endfunction

    task automatic reset_dut();
        @(negedge cpu_clk);
        cpu_rst_n = 1'b0;
        mem_read  = 1'b1;
        mem_write = 1'b1;
        #1;
        check_eq("rst_hazard", {31'b0, mem_hazard}, 0);
        @(negedge cpu_clk);
        check_eq("rst_rdata", mem_rdata, 0);
        check_eq("rst_err", {31'b0, err_oob}, 0);
        @(negedge cpu_clk);
        mem_read  = 1'b0;
        mem_write = 1'b0;
        cpu_rst_n = 1'b1;
        ref_rdata       = '0;
        ref_rdata_known = 1'b1;
        ref_err         = 1'b0;
    endtask

    task automatic txn(input bit rd, input logic [AW-1:0] ra, input bit wr,
                       input logic [AW-1:0] wa, input logic [DW-1:0] wd,
                       input bit scramble, input string tag);
        int cyc;
        @(negedge cpu_clk);
        check_eq({tag, "_idle"}, {31'b0, mem_hazard}, 0);
        mem_read  = rd;
        mem_raddr = ra;
        mem_write = wr;
        mem_waddr = wa;
        mem_wdata = wd;
        #1;
        if (wr) begin
            if (addr_oob(wa)) ref_err = 1'b1;
            else ref_mem[int'(wa / 4)] = wd;
        end
        if (rd) begin
            if (addr_oob(ra)) begin
                ref_rdata       = '0;
                ref_rdata_known = 1'b1;
                ref_err         = 1'b1;
            end else if (ref_mem.exists(int'(ra / 4))) begin
                ref_rdata       = ref_mem[int'(ra / 4)];
                ref_rdata_known = 1'b1;
            end else begin
                ref_rdata_known = 1'b0;
            end
        end
        cyc = 0;
        while (mem_hazard === 1'b1 && cyc < 40) begin
            cyc++;
            @(negedge cpu_clk);
            if (scramble) begin
                mem_raddr = $urandom;
                mem_waddr = $urandom;
                mem_wdata = $urandom;
            end
            #1;
        end
        check_eq({tag, "_lat"}, cyc, LAT + 1);
        if (ref_rdata_known) check_eq({tag, "_rdata"}, mem_rdata, ref_rdata);
        check_eq({tag, "_err"}, {31'b0, err_oob}, {31'b0, ref_err});
        mem_read  = 1'b0;
        mem_write = 1'b0;
    endtask

    function automatic logic [AW-1:0] rand_addr();
        if ($urandom_range(7) == 0) begin
            return ($urandom_range(1) == 0) ? (32'h1000 + ($urandom & 32'hFFFF)) : $urandom | 32'h8000_0000;
        end
        return ($urandom_range(15) * 4) + $urandom_range(3);
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [DW-1:0] w0;
        bit rd, wr;
        cpu_rst_n = 1'b0;
        mem_read  = 1'b0;
        mem_write = 1'b0;
        mem_raddr = '0;
        mem_waddr = '0;
        mem_wdata = '0;
        ref_rdata = '0;
        ref_rdata_known = 1'b1;
        ref_err = 1'b0;
        repeat (3) @(posedge cpu_clk);
        reset_dut();

        for (int i = 0; i < 16; i++) txn(0, 0, 1, i * 4, $urandom, 0, "fill");

        txn(0, 0, 1, 32'h10, 32'hDEADBEEF, 0, "wr_10");
        txn(1, 32'h10, 0, 0, 0, 0, "rd_10");
        check_eq("rd_10_value", mem_rdata, 32'hDEADBEEF);

        txn(0, 0, 1, 32'h10, 32'h11223344, 0, "wr_10b");
        txn(1, 32'h13, 0, 0, 0, 0, "rd_13");
        check_eq("rd_13_value", mem_rdata, 32'h11223344);
        txn(1, 32'h20, 1, 32'h20, 32'hA5A5A5A5, 0, "rw_20");
        check_eq("rw_20_value", mem_rdata, 32'hA5A5A5A5);

        txn(1, 32'h0, 0, 0, 0, 0, "rd_0_pre");
        w0 = mem_rdata;
        txn(0, 0, 1, 32'h1000, 32'hCAFEF00D, 0, "wr_oob");
        check_eq("wr_oob_flag", {31'b0, err_oob}, 1);
        txn(1, 32'h0, 0, 0, 0, 0, "rd_0_post");
        check_eq("oob_no_alias", mem_rdata, w0);
        txn(1, 32'h1000, 0, 0, 0, 0, "rd_oob");
        check_eq("rd_oob_zero", mem_rdata, 0);
        reset_dut();

        // Reset lands on the completing edge of a write; the write must not commit.
        @(negedge cpu_clk);
        mem_write = 1'b1;
        mem_waddr = 32'h8;
        mem_wdata = 32'h55;
        @(negedge cpu_clk);
        @(negedge cpu_clk);
        cpu_rst_n = 1'b0;
        #1;
        check_eq("abort_hazard", {31'b0, mem_hazard}, 0);
        @(negedge cpu_clk);
        check_eq("abort_rdata", mem_rdata, 0);
        mem_write = 1'b0;
        cpu_rst_n = 1'b1;
        ref_rdata = '0;
        ref_err = 1'b0;
        txn(1, 32'h8, 0, 0, 0, 0, "rd_8_abort");

        txn(0, 0, 1, 32'h14, 32'h0BADF00D, 1, "wr_scr");
        txn(1, 32'h14, 0, 0, 0, 0, "rd_scr");
        check_eq("scr_value", mem_rdata, 32'h0BADF00D);

        for (int i = 0; i < 200; i++) begin
            rd = $urandom_range(1);
            wr = $urandom_range(1);
            if (!rd && !wr) rd = 1'b1;
            if ($urandom_range(39) == 0) reset_dut();
            txn(rd, rand_addr(), wr, rand_addr(), $urandom, $urandom_range(1), "rand");
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
